// File: rtl/neuron_act_collector.sv
// Bias-add, round/shift/saturate and collect N_IN activations into one parallel vector.
// Optional ReLU clamp is enabled by defining ACT_RELU_EN.
module neuron_act_collector #(
  parameter int N_IN  = 20,
  parameter int IN_W  = 13,
  parameter int OUT_W = 9,
  parameter int SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_neuron,
  input  logic signed [IN_W-1:0]  bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_IN*OUT_W-1:0]   out_act
);

  localparam int SUM_W = IN_W + 2;
  // One extra bit so adding the rounding constant can never wrap.
  localparam int RND_W = SUM_W + 1;
  localparam int CNT_W = $clog2(N_IN + 1);
  localparam int IDX_W = $clog2(N_IN);
  localparam int RND_I = (1 << SHIFT) >> 1;
  localparam int SAT_HI_I = (1 << (OUT_W - 1)) - 1;
`ifdef ACT_RELU_EN
  localparam int SAT_LO_I = 0;
`else
  localparam int SAT_LO_I = -(1 << (OUT_W - 1));
`endif
  localparam logic signed [RND_W-1:0] RND    = RND_W'(RND_I);
  localparam logic signed [RND_W-1:0] SAT_HI = RND_W'(SAT_HI_I);
  localparam logic signed [RND_W-1:0] SAT_LO = RND_W'(SAT_LO_I);

  logic [CNT_W-1:0]        acc_cnt;
  logic [CNT_W-1:0]        wr_cnt;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] sum_q;
  logic [OUT_W-1:0]        bank [N_IN];

  logic                    accept;
  logic                    drain;
  logic signed [RND_W-1:0] rounded;
  logic signed [RND_W-1:0] shifted;
  logic [OUT_W-1:0]        act_val;

  // Both ports transfer on the rising edge where valid && ready; a producer holds
  // its payload stable until that edge, and ready never depends on valid.
  assign in_ready = !rst && (acc_cnt < CNT_W'(N_IN));
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_comb begin
    rounded = RND_W'(sum_q) + RND;
    shifted = rounded >>> SHIFT;
    if (shifted > SAT_HI) begin
      act_val = OUT_W'(SAT_HI_I);
    end else if (shifted < SAT_LO) begin
      act_val = OUT_W'(SAT_LO_I);
    end else begin
      act_val = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      s1_valid  <= 1'b0;
      sum_q     <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        bank[i] <= '0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        sum_q   <= SUM_W'(in_neuron) + SUM_W'(bias);
        acc_cnt <= acc_cnt + 1'b1;
      end
      // out_valid is set on the same edge as the last slot write.
      if (s1_valid) begin
        bank[wr_cnt[IDX_W-1:0]] <= act_val;
        wr_cnt                  <= wr_cnt + 1'b1;
        out_valid               <= (wr_cnt == CNT_W'(N_IN - 1));
      end
      if (drain) begin
        acc_cnt   <= '0;
        wr_cnt    <= '0;
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_pack
    assign out_act[g*OUT_W +: OUT_W] = bank[g];
  end

endmodule

// File: tb/tb_neuron_act_collector.sv
// Randomized self-checking bench for neuron_act_collector with an arithmetic reference model.
module tb_neuron_act_collector;
  localparam int N_IN  = 20;
  localparam int IN_W  = 13;
  localparam int OUT_W = 9;
  localparam int SHIFT = 4;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic signed [IN_W-1:0] in_neuron;
  logic signed [IN_W-1:0] bias;
  logic out_valid;
  logic out_ready;
  logic [N_IN*OUT_W-1:0] out_act;

  logic [OUT_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;

  neuron_act_collector #(.N_IN(N_IN), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_neuron(in_neuron), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .out_act(out_act)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: real-number rounding of (in+bias)/2^SHIFT, floor, then clamp.
  function automatic logic [OUT_W-1:0] ref_act(input int v, input int b);
    int s, d, q, lo, hi;
    d = 1 << SHIFT;
    s = v + b + d / 2;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    hi = (1 << (OUT_W - 1)) - 1;
`ifdef ACT_RELU_EN
    lo = 0;
`else
    lo = -(1 << (OUT_W - 1));
`endif
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[OUT_W-1:0];
  endfunction

  function automatic int rand_val();
    int m;
    m = int'($urandom_range(0, 3));
    if (m == 0) return ($urandom_range(0, 1) == 1) ? 4095 : -4096;
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int v, input int b);
    bit done;
    done = 0;
    in_valid  = 1;
    in_neuron = v[IN_W-1:0];
    bias      = b[IN_W-1:0];
    for (int t = 0; t < 64 && !done; t++) begin
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back(ref_act(v, b));
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready got=0 exp=1");
    end else begin
      last_acc = cyc;
    end
  endtask

  task automatic wait_ov(input int max, output bit ok);
    ok = 0;
    for (int t = 0; t < max && !ok; t++) begin
      if (out_valid) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0; in_neuron = '0; bias = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_act !== '0) begin bad++; $display("FAIL reset_out_act got=%0h exp=0", out_act); end
    rst = 0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_rounding();
    int v_tab[7] = '{100, -100, 7, 8, 4095, -4096, 0};
    int b_tab[7] = '{0, 0, 0, 0, 4095, -4096, -16};
`ifdef ACT_RELU_EN
    int e_tab[7] = '{6, 0, 0, 1, 255, 0, 0};
`else
    int e_tab[7] = '{6, -6, 0, 1, 255, -256, -1};
`endif
    logic [OUT_W-1:0] e;
    bit ok;
    out_ready = 1;
    for (int i = 0; i < 7; i++) send(v_tab[i], b_tab[i]);
    for (int i = 7; i < N_IN; i++) send(rand_val(), rand_val());
    wait_ov(10, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rounding_out_valid got=0 exp=1");
    end else begin
      for (int i = 0; i < 7; i++) begin
        e = OUT_W'(e_tab[i]);
        total++;
        if (out_act[i*OUT_W +: OUT_W] !== e) begin
          bad++; $display("FAIL rounding_const slot%0d got=%0d exp=%0d", i, $signed(out_act[i*OUT_W +: OUT_W]), $signed(e));
        end
      end
      for (int i = 0; i < N_IN; i++) begin
        total++;
        if (out_act[i*OUT_W +: OUT_W] !== exp_q[i]) begin
          bad++; $display("FAIL rounding_model slot%0d got=%0d exp=%0d", i, $signed(out_act[i*OUT_W +: OUT_W]), $signed(exp_q[i]));
        end
      end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_order_fill();
    int first;
    logic [OUT_W-1:0] e;
    first = 0;
    out_ready = 1;
    for (int k = 1; k <= N_IN; k++) begin
      send(16 * k, 0);
      if (k == 1) first = last_acc;
    end
    total++; if (last_acc !== first + N_IN - 1) begin bad++; $display("FAIL order_b2b last_accept got=%0d exp=%0d", last_acc, first + N_IN - 1); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL order_early_valid got=%0b exp=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL order_valid_at_e0+n got=%0b exp=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL order_full_in_ready got=%0b exp=0", in_ready); end
    for (int i = 0; i < N_IN; i++) begin
      e = OUT_W'(i + 1);
      total++;
      if (out_act[i*OUT_W +: OUT_W] !== e) begin
        bad++; $display("FAIL order_slot slot%0d got=%0d exp=%0d", i, $signed(out_act[i*OUT_W +: OUT_W]), i + 1);
      end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL order_valid_one_cycle got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL order_in_ready_return got=%0b exp=1", in_ready); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [N_IN*OUT_W-1:0] snap;
    logic [OUT_W-1:0] x_exp;
    int x_v, x_b;
    bit ok;
    out_ready = 0;
    for (int i = 0; i < N_IN; i++) send(rand_val(), rand_val());
    wait_ov(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_out_valid got=0 exp=1"); end
    snap = out_act;
    x_v = rand_val(); x_b = rand_val();
    x_exp = ref_act(x_v, x_b);
    in_valid = 1; in_neuron = x_v[IN_W-1:0]; bias = x_b[IN_W-1:0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d got=%0b exp=0", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c%0d got=%0b exp=1", c, out_valid); end
      total++; if (out_act !== snap) begin bad++; $display("FAIL bp_stable c%0d got=%0h exp=%0h", c, out_act, snap); end
    end
    for (int i = 0; i < N_IN; i++) begin
      total++;
      if (out_act[i*OUT_W +: OUT_W] !== exp_q[i]) begin
        bad++; $display("FAIL bp_vec1 slot%0d got=%0d exp=%0d", i, $signed(out_act[i*OUT_W +: OUT_W]), $signed(exp_q[i]));
      end
    end
    exp_q.delete();
    out_ready = 1;
    send(x_v, x_b);
    for (int i = 1; i < N_IN; i++) send(rand_val(), rand_val());
    wait_ov(10, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_vec2_valid got=0 exp=1");
    end else begin
      total++;
      if (out_act[OUT_W-1:0] !== x_exp) begin
        bad++; $display("FAIL bp_held_slot0 got=%0d exp=%0d", $signed(out_act[OUT_W-1:0]), $signed(x_exp));
      end
      for (int i = 0; i < N_IN; i++) begin
        total++;
        if (out_act[i*OUT_W +: OUT_W] !== exp_q[i]) begin
          bad++; $display("FAIL bp_vec2 slot%0d got=%0d exp=%0d", i, $signed(out_act[i*OUT_W +: OUT_W]), $signed(exp_q[i]));
        end
      end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_gapped();
    int n, k;
    n = 0; k = 0;
    out_ready = 1;
    while (n < N_IN) begin
      if ((k % 4) == 0 || (k % 4) == 3) begin
        send(rand_val(), rand_val());
        n++;
      end else begin
        @(negedge clk);
      end
      k++;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_early_valid got=%0b exp=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gap_valid_edge got=%0b exp=1", out_valid); end
    for (int i = 0; i < N_IN; i++) begin
      total++;
      if (out_act[i*OUT_W +: OUT_W] !== exp_q[i]) begin
        bad++; $display("FAIL gap_slot slot%0d got=%0d exp=%0d", i, $signed(out_act[i*OUT_W +: OUT_W]), $signed(exp_q[i]));
      end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    out_ready = 1;
    for (int i = 0; i < 7; i++) send(rand_val(), rand_val());
    rst = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%0b exp=0", in_ready); end
    @(negedge clk);
    rst = 0;
    #1;
    total++; if (out_act !== '0) begin bad++; $display("FAIL midrst_bank_clear got=%0h exp=0", out_act); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) begin
      send(rand_val(), rand_val());
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_early_valid n%0d got=%0b exp=0", i, out_valid); end
    end
    wait_ov(4, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL midrst_valid got=0 exp=1");
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        total++;
        if (out_act[i*OUT_W +: OUT_W] !== exp_q[i]) begin
          bad++; $display("FAIL midrst_slot slot%0d got=%0d exp=%0d", i, $signed(out_act[i*OUT_W +: OUT_W]), $signed(exp_q[i]));
        end
      end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok;
    for (int vct = 0; vct < 4; vct++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N_IN; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(rand_val(), rand_val());
      end
      wait_ov(10, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL rand_valid v%0d got=0 exp=1", vct);
      end else begin
        if (!out_ready) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rand_hold v%0d got=%0b exp=1", vct, out_valid); end
        end
        for (int i = 0; i < N_IN; i++) begin
          total++;
          if (out_act[i*OUT_W +: OUT_W] !== exp_q[i]) begin
            bad++; $display("FAIL rand_slot v%0d slot%0d got=%0d exp=%0d", vct, i, $signed(out_act[i*OUT_W +: OUT_W]), $signed(exp_q[i]));
          end
        end
      end
      out_ready = 1;
      exp_q.delete();
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_order_fill();
    test_backpressure();
    test_gapped();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
